// File: rtl/sensor_frame_emitter.sv
// ---------------------------------------------------------------------------
// sensor_frame_emitter
//
// Purpose:
//   Stands in for the image sensor on the parallel pixel bus. Emits one frame
//   per start request with sensor-like timing (pixclk, line_valid, frame_valid,
//   12-bit dout). Pixels come either from a frame-buffer read port (replay) or
//   from an internal ramp, dout = (row + col) mod 4096. done pulses once the
//   frame and its vertical blanking have been sent.
//
// Ports:
//   clock        in   1       system clock
//   reset_bar    in   1       synchronous reset, active low
//   start        in   1       one-cycle request to emit a frame (IDLE only)
//   pattern      in   1       0 = replay from frame buffer, 1 = ramp
//   busy         out  1       high from accept until done
//   done         out  1       one-cycle pulse at the end of vertical blanking
//   readEnable   out  1       frame-buffer read strobe
//   readAddr     out  ADDR_W  frame-buffer address, row*WIDTH+col
//   readData     in   12      read data, valid the cycle after readEnable
//   pixclk       out  1       emitted pixel clock
//   line_valid   out  1       emitted LV
//   frame_valid  out  1       emitted FV
//   dout         out  12      emitted pixel data
// ---------------------------------------------------------------------------
module sensor_frame_emitter #(
    parameter int WIDTH        = 64,
    parameter int HEIGHT       = 48,
    parameter int HBLANK       = 8,
    parameter int VBLANK_LINES = 2,
    parameter int PIXCLK_DIV   = 1,
    parameter int ADDR_W       = 12
) (
    input  logic              clock,
    input  logic              reset_bar,
    input  logic              start,
    input  logic              pattern,
    output logic              busy,
    output logic              done,
    output logic              readEnable,
    output logic [ADDR_W-1:0] readAddr,
    input  logic [11:0]       readData,
    output logic              pixclk,
    output logic              line_valid,
    output logic              frame_valid,
    output logic [11:0]       dout
);

    localparam int VBL_SLOTS = VBLANK_LINES * (WIDTH + HBLANK);

    localparam logic [15:0] SLOT_LAST = 16'(2 * PIXCLK_DIV - 1);
    localparam logic [15:0] DIV_CNT   = 16'(PIXCLK_DIV);
    localparam logic [15:0] COL_LAST  = 16'(WIDTH - 1);
    localparam logic [15:0] ROW_LAST  = 16'(HEIGHT - 1);
    localparam logic [15:0] HB_LAST   = 16'(HBLANK - 1);
    localparam logic [15:0] VB_LAST   = 16'(VBL_SLOTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_ACTIVE,
        S_HGAP,
        S_TAIL,
        S_VBLANK
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         slotCnt_q, slotCnt_d;
    logic [15:0]         phaseCnt_q, phaseCnt_d;
    logic [15:0]         col_q, col_d;
    logic [15:0]         row_q, row_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ramp_q, ramp_d;
    logic                lv_q, lv_d;
    logic                fv_q, fv_d;
    logic [11:0]         dout_q, dout_d;
    logic                pixclk_q, pixclk_d;
    logic                readEnable_q, readEnable_d;
    logic                readValid_q, readValid_d;
    logic [ADDR_W-1:0]   readAddr_q, readAddr_d;
    logic [ADDR_W-1:0]   addrCnt_q, addrCnt_d;
    logic [11:0]         prefetch_q, prefetch_d;

    logic                slotLast;
    logic                issueRead;
    logic                frameStart;
    logic [ADDR_W-1:0]   addrNow;

    // Next-state logic. Everything visible on the bus is recomputed on the
    // last cycle of a slot so it appears in slot cycle 0, right after the
    // pixclk falling edge, and stays put across the rising edge.
    always_comb begin
        state_d      = state_q;
        phaseCnt_d   = phaseCnt_q;
        col_d        = col_q;
        row_d        = row_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        ramp_d       = ramp_q;
        lv_d         = lv_q;
        fv_d         = fv_q;
        dout_d       = dout_q;
        readEnable_d = 1'b0;
        readValid_d  = readEnable_q;
        readAddr_d   = readAddr_q;
        addrCnt_d    = addrCnt_q;
        prefetch_d   = prefetch_q;
        issueRead    = 1'b0;
        frameStart   = 1'b0;
        addrNow      = addrCnt_q;

        slotLast  = (slotCnt_q == SLOT_LAST);
        slotCnt_d = slotLast ? 16'd0 : slotCnt_q + 16'd1;
        pixclk_d  = (slotCnt_d >= DIV_CNT);

        // A start in IDLE is only latched here; the frame begins at the next
        // slot boundary so the first FV edge lands on a pixclk falling edge.
        if (state_q == S_IDLE && !busy_q && start) begin
            busy_d = 1'b1;
            ramp_d = pattern;
        end

        if (readValid_q) begin
            prefetch_d = readData;
        end

        if (slotLast) begin
            case (state_q)
                S_IDLE: begin
                    if (busy_q) begin
                        state_d    = S_LEAD;
                        phaseCnt_d = 16'd0;
                        row_d      = 16'd0;
                        col_d      = 16'd0;
                    end
                end
                S_LEAD, S_HGAP: begin
                    if (phaseCnt_q == HB_LAST) begin
                        state_d = S_ACTIVE;
                        col_d   = 16'd0;
                    end else begin
                        phaseCnt_d = phaseCnt_q + 16'd1;
                    end
                end
                S_ACTIVE: begin
                    if (col_q == COL_LAST) begin
                        col_d      = 16'd0;
                        phaseCnt_d = 16'd0;
                        if (row_q == ROW_LAST) begin
                            row_d   = 16'd0;
                            state_d = S_TAIL;
                        end else begin
                            row_d   = row_q + 16'd1;
                            state_d = S_HGAP;
                        end
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                end
                S_TAIL: begin
                    if (phaseCnt_q == HB_LAST) begin
                        state_d    = S_VBLANK;
                        phaseCnt_d = 16'd0;
                    end else begin
                        phaseCnt_d = phaseCnt_q + 16'd1;
                    end
                end
                S_VBLANK: begin
                    if (phaseCnt_q == VB_LAST) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        phaseCnt_d = phaseCnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            fv_d = (state_d != S_IDLE) && (state_d != S_VBLANK);
            lv_d = (state_d == S_ACTIVE);

            // On a one-cycle-per-half-period pixclk the read data arrives on
            // the same edge that loads dout, so take it straight from the port.
            dout_d = 12'd0;
            if (state_d == S_ACTIVE) begin
                if (ramp_q) begin
                    dout_d = 12'(row_d + col_d);
                end else begin
                    dout_d = readValid_q ? readData : prefetch_q;
                end
            end

            // The upcoming slot fetches the pixel shown in the slot after it:
            // the last LEAD/HGAP slot fetches column 0, every ACTIVE slot but
            // the last column fetches its right-hand neighbour.
            issueRead = ((state_d == S_LEAD || state_d == S_HGAP) && phaseCnt_d == HB_LAST)
                      || (state_d == S_ACTIVE && col_d != COL_LAST);

            frameStart = (state_q == S_IDLE) && (state_d == S_LEAD);
            addrNow    = frameStart ? '0 : addrCnt_q;
            addrCnt_d  = addrNow;

            if (issueRead && !ramp_q) begin
                readEnable_d = 1'b1;
                readAddr_d   = addrNow;
                addrCnt_d    = addrNow + ADDR_W'(1);
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_bar) begin
            state_q      <= S_IDLE;
            slotCnt_q    <= 16'd0;
            phaseCnt_q   <= 16'd0;
            col_q        <= 16'd0;
            row_q        <= 16'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ramp_q       <= 1'b0;
            lv_q         <= 1'b0;
            fv_q         <= 1'b0;
            dout_q       <= 12'd0;
            pixclk_q     <= 1'b0;
            readEnable_q <= 1'b0;
            readValid_q  <= 1'b0;
            readAddr_q   <= '0;
            addrCnt_q    <= '0;
            prefetch_q   <= 12'd0;
        end else begin
            state_q      <= state_d;
            slotCnt_q    <= slotCnt_d;
            phaseCnt_q   <= phaseCnt_d;
            col_q        <= col_d;
            row_q        <= row_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ramp_q       <= ramp_d;
            lv_q         <= lv_d;
            fv_q         <= fv_d;
            dout_q       <= dout_d;
            pixclk_q     <= pixclk_d;
            readEnable_q <= readEnable_d;
            readValid_q  <= readValid_d;
            readAddr_q   <= readAddr_d;
            addrCnt_q    <= addrCnt_d;
            prefetch_q   <= prefetch_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign readEnable  = readEnable_q;
    assign readAddr    = readAddr_q;
    assign pixclk      = pixclk_q;
    assign line_valid  = lv_q;
    assign frame_valid = fv_q;
    assign dout        = dout_q;

endmodule

// File: tb/tb_sensor_frame_emitter.sv
// ---------------------------------------------------------------------------
// tb_sensor_frame_emitter
//
// Drives a small 4x2 frame geometry through two emitters: one with a
// one-cycle pixclk half-period (main checks) and one with a three-cycle
// half-period (edge alignment and slot length). Expected pixels are queued
// when a frame is requested and popped as the emitter shows them.
// ---------------------------------------------------------------------------
module tb_sensor_frame_emitter;

    logic        clock = 1'b0;
    logic        reset_bar = 1'b0;
    logic        start = 1'b0;
    logic        pattern = 1'b0;
    logic        start2 = 1'b0;
    logic [11:0] readData = 12'd0;
    logic [11:0] readData2 = 12'd0;

    logic        busy, done, readEnable, pixclk, lv, fv;
    logic [11:0] readAddr, dout;
    logic        busy2, done2, readEnable2, pixclk2, lv2, fv2;
    logic [11:0] readAddr2, dout2;

    int assertCount = 0;
    int failCount = 0;

    logic [11:0] expQ[$];
    int          readSlotQ[$];
    bit          expectReads = 1'b0;

    int slotIdx = 0, fvSlots = 0, fvFallSlot = 0, doneSlot = 0, lvPulses = 0;
    int lvRun = 0, doneCount = 0, readsTotal = 0, readsBase = 0;
    logic prevLv = 1'b0, prevFv = 1'b0, prevBusy = 1'b0;

    int fvCycles2 = 0, lvCycles2 = 0, sinceFall2 = 0;
    bit seenFall2 = 1'b0;
    logic prevPix2 = 1'b0, prevLv2 = 1'b0, prevFv2 = 1'b0;
    logic [11:0] prevDout2 = 12'd0;

    sensor_frame_emitter #(
        .WIDTH(4), .HEIGHT(2), .HBLANK(2), .VBLANK_LINES(1), .PIXCLK_DIV(1), .ADDR_W(12)
    ) dut (
        .clock(clock), .reset_bar(reset_bar), .start(start), .pattern(pattern),
        .busy(busy), .done(done), .readEnable(readEnable), .readAddr(readAddr),
        .readData(readData), .pixclk(pixclk), .line_valid(lv), .frame_valid(fv),
        .dout(dout)
    );

    sensor_frame_emitter #(
        .WIDTH(4), .HEIGHT(2), .HBLANK(2), .VBLANK_LINES(1), .PIXCLK_DIV(3), .ADDR_W(12)
    ) dut2 (
        .clock(clock), .reset_bar(reset_bar), .start(start2), .pattern(1'b1),
        .busy(busy2), .done(done2), .readEnable(readEnable2), .readAddr(readAddr2),
        .readData(readData2), .pixclk(pixclk2), .line_valid(lv2), .frame_valid(fv2),
        .dout(dout2)
    );

    always #5 clock = ~clock;

    // Frame-buffer model: memory[a] = a + 100, one-cycle read latency.
    always @(posedge clock) begin
        if (readEnable) begin
            readData <= 12'(readAddr + 12'd100);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic pat);
        @(posedge clock) #2;
        pattern = pat;
        start = 1'b1;
        @(posedge clock) #2;
        start = 1'b0;
    endtask

    task automatic pushRamp();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                expQ.push_back(12'(r + c));
            end
        end
    endtask

    task automatic waitDone(input int limit);
        bit got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clock);
            if (done) got = 1'b1;
        end
        #1;
        checkOutput("done within budget", 32'(got), 32'd1);
    endtask

    // Slot-level monitor for the main emitter; every negedge with pixclk low
    // is the middle of slot cycle 0.
    always @(negedge clock) begin
        if (!reset_bar) begin
            prevLv = 1'b0;
            prevFv = 1'b0;
            prevBusy = 1'b0;
            lvRun = 0;
        end else begin
            doneCount += int'(done);
            if (busy && !prevBusy) readsBase = readsTotal;
            prevBusy = busy;
            if (!pixclk) begin
                slotIdx++;
                if (fv) fvSlots++;
                if (prevFv && !fv) fvFallSlot = slotIdx;
                if (done) doneSlot = slotIdx;
                if (lv) begin
                    lvRun++;
                    checkOutput("pixel expected", 32'(expQ.size() != 0), 32'd1);
                    if (expQ.size() != 0) checkOutput("pixel value", 32'(dout), 32'(expQ.pop_front()));
                    if (expectReads) begin
                        checkOutput("read issued for pixel", 32'(readSlotQ.size() != 0), 32'd1);
                        if (readSlotQ.size() != 0)
                            checkOutput("read one slot ahead", 32'(slotIdx - readSlotQ.pop_front()), 32'd1);
                    end
                end else begin
                    checkOutput("dout zero when LV low", 32'(dout), 32'd0);
                    if (prevLv) begin
                        checkOutput("LV pulse width", 32'(lvRun), 32'd4);
                        lvPulses++;
                        lvRun = 0;
                    end
                end
                if (readEnable) begin
                    checkOutput("read address", 32'(readAddr), 32'(readsTotal - readsBase));
                    readsTotal++;
                    readSlotQ.push_back(slotIdx);
                end
                prevLv = lv;
                prevFv = fv;
            end else begin
                checkOutput("readEnable one cycle", 32'(readEnable), 32'd0);
            end
        end
    end

    // Cycle-level monitor for the divide-by-3 emitter.
    always @(negedge clock) begin
        if (!reset_bar) begin
            prevPix2 = 1'b0;
            prevLv2 = 1'b0;
            prevFv2 = 1'b0;
            prevDout2 = 12'd0;
            seenFall2 = 1'b0;
            sinceFall2 = 0;
        end else begin
            sinceFall2++;
            if ({lv2, fv2, dout2} !== {prevLv2, prevFv2, prevDout2})
                checkOutput("div3 change on pixclk fall", 32'({prevPix2, pixclk2}), 32'd2);
            if (prevPix2 && !pixclk2) begin
                if (seenFall2) checkOutput("div3 slot length", 32'(sinceFall2), 32'd6);
                seenFall2 = 1'b1;
                sinceFall2 = 0;
            end
            if (fv2) fvCycles2++;
            if (lv2) lvCycles2++;
            checkOutput("div3 no reads", 32'({readEnable2, readAddr2}), 32'd0);
            prevPix2 = pixclk2;
            prevLv2 = lv2;
            prevFv2 = fv2;
            prevDout2 = dout2;
        end
    end

    initial begin
        int fv0, lvp0, done0, reads0, fvc0, lvc0;
        logic prevPix;
        bit got;

        $display("[TB] start");
        repeat (3) @(negedge clock);
        checkOutput("reset outputs", 32'({pixclk, lv, fv, busy, done, readEnable, dout, readAddr}), 32'd0);
        checkOutput("reset outputs div3", 32'({pixclk2, lv2, fv2, busy2, done2, dout2}), 32'd0);
        @(posedge clock) #2;
        reset_bar = 1'b1;

        // Idle: pixclk free-runs, everything else quiet.
        @(negedge clock);
        prevPix = pixclk;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checkOutput("idle pixclk toggles", 32'(pixclk), 32'(!prevPix));
            checkOutput("idle outputs", 32'({lv, fv, dout, busy, done}), 32'd0);
            prevPix = pixclk;
        end

        // Ramp frame.
        fv0 = fvSlots; lvp0 = lvPulses; done0 = doneCount; reads0 = readsTotal;
        pushRamp();
        applyStimulus(1'b1);
        checkOutput("busy after accept", 32'(busy), 32'd1);
        waitDone(500);
        checkOutput("busy low at done", 32'(busy), 32'd0);
        checkOutput("FV slots", 32'(fvSlots - fv0), 32'd14);
        checkOutput("LV pulses", 32'(lvPulses - lvp0), 32'd2);
        checkOutput("done after FV fall", 32'(doneSlot - fvFallSlot), 32'd6);
        checkOutput("ramp pixels consumed", 32'(expQ.size()), 32'd0);
        checkOutput("ramp issues no reads", 32'(readsTotal - reads0), 32'd0);
        checkOutput("one done per frame", 32'(doneCount - done0), 32'd1);

        // Divide-by-3 ramp frame.
        fvc0 = fvCycles2; lvc0 = lvCycles2;
        @(posedge clock) #2;
        start2 = 1'b1;
        @(posedge clock) #2;
        start2 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clock);
            if (done2) got = 1'b1;
        end
        #1;
        checkOutput("div3 done within budget", 32'(got), 32'd1);
        checkOutput("div3 FV cycles", 32'(fvCycles2 - fvc0), 32'd84);
        checkOutput("div3 LV cycles", 32'(lvCycles2 - lvc0), 32'd48);

        // Second start mid-frame is ignored, pattern change included.
        done0 = doneCount;
        pushRamp();
        applyStimulus(1'b1);
        repeat (10) @(posedge clock);
        applyStimulus(1'b0);
        waitDone(500);
        repeat (60) @(negedge clock);
        checkOutput("mid-frame start ignored", 32'(doneCount - done0), 32'd1);
        checkOutput("idle after ignored start", 32'({busy, fv}), 32'd0);
        checkOutput("ignored-start pixels", 32'(expQ.size()), 32'd0);

        // Replay frame, then a new frame requested the cycle after done.
        reads0 = readsTotal;
        expectReads = 1'b1;
        for (int a = 0; a < 8; a++) expQ.push_back(12'(a + 100));
        applyStimulus(1'b0);
        waitDone(500);
        expectReads = 1'b0;
        checkOutput("replay read count", 32'(readsTotal - reads0), 32'd8);
        checkOutput("replay pixels consumed", 32'(expQ.size()), 32'd0);
        checkOutput("replay reads all used", 32'(readSlotQ.size()), 32'd0);
        done0 = doneCount;
        pushRamp();
        @(posedge clock) #2;
        pattern = 1'b1;
        start = 1'b1;
        @(posedge clock) #2;
        start = 1'b0;
        checkOutput("start after done accepted", 32'(busy), 32'd1);
        waitDone(500);
        checkOutput("frame after done pixels", 32'(expQ.size()), 32'd0);
        checkOutput("frame after done count", 32'(doneCount - done0), 32'd1);

        // Reset pulse in the middle of an active line.
        pushRamp();
        applyStimulus(1'b1);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            if (lv) got = 1'b1;
        end
        checkOutput("reached ACTIVE", 32'(got), 32'd1);
        done0 = doneCount;
        @(posedge clock) #2;
        reset_bar = 1'b0;
        @(posedge clock) #2;
        reset_bar = 1'b1;
        @(negedge clock);
        checkOutput("outputs after reset", 32'({pixclk, lv, fv, busy, done, readEnable, dout}), 32'd0);
        repeat (100) @(negedge clock);
        checkOutput("no done after reset", 32'(doneCount - done0), 32'd0);
        checkOutput("idle after reset", 32'(busy), 32'd0);
        expQ.delete();
        pushRamp();
        applyStimulus(1'b1);
        waitDone(500);
        checkOutput("frame after reset", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
